// File: rtl/sys_rx_cmd_ctrl.sv
// rtl/sys_rx_cmd_ctrl.sv - RX frame command sequencer driving register file and ALU controls
module sys_rx_cmd_ctrl #(
  parameter int WIDTH          = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH-1:0]      RX_P_DATA,
  input  logic                  RX_D_VALID,
  input  logic                  ALU_OUT_VALID,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [WIDTH-1:0]      WrData,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  ALU_EN,
  output logic                  CLK_GATE_EN,
  output logic                  CMD_ERR
);

  localparam int                CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]     TO_MAX = CW'(TIMEOUT_CYCLES);
  localparam logic [WIDTH-1:0]  OP_WR  = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0]  OP_RD  = WIDTH'(8'hBB);
  localparam logic [WIDTH-1:0]  OP_ALU = WIDTH'(8'hCC);
  localparam logic [WIDTH-1:0]  OP_NOP = WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_OPA,
    S_OPB,
    S_FUN,
    S_ALU_WAIT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          w_timeout;
  logic [CW-1:0] w_cnt_inc;

  // Idle-time limit reached while a command is in progress
  assign w_timeout = (r_state != S_IDLE) && (r_cnt == TO_MAX);
  // Saturating increment so the counter can never wrap back to a small value
  assign w_cnt_inc = (r_cnt == TO_MAX) ? r_cnt : r_cnt + 1'b1;

  // Command FSM with registered outputs; strobes default low every cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      Address     <= '0;
      WrData      <= '0;
      ALU_FUN     <= '0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      CMD_ERR     <= 1'b0;
    end else begin
      WrEn    <= 1'b0;
      RdEn    <= 1'b0;
      CMD_ERR <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (RX_D_VALID) begin
            case (RX_P_DATA)
              OP_WR:   r_state <= S_WR_ADDR;
              OP_RD:   r_state <= S_RD_ADDR;
              OP_ALU:  r_state <= S_OPA;
              OP_NOP:  r_state <= S_FUN;
              default: CMD_ERR <= 1'b1;
            endcase
          end
        end
        S_ALU_WAIT: begin
          if (ALU_OUT_VALID) begin
            // completion has priority; a frame arriving alongside is dropped
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            CMD_ERR     <= RX_D_VALID;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end else if (w_timeout) begin
            CMD_ERR     <= 1'b1;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end else begin
            // frames are not consumed while the ALU is busy
            CMD_ERR <= RX_D_VALID;
            r_cnt   <= w_cnt_inc;
          end
        end
        default: begin
          if (RX_D_VALID) begin
            r_cnt <= '0;
            case (r_state)
              S_WR_ADDR: begin
                Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                r_state <= S_WR_DATA;
              end
              S_WR_DATA: begin
                WrData  <= RX_P_DATA;
                WrEn    <= 1'b1;
                r_state <= S_IDLE;
              end
              S_RD_ADDR: begin
                Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                RdEn    <= 1'b1;
                r_state <= S_IDLE;
              end
              S_OPA: begin
                Address <= '0;
                WrData  <= RX_P_DATA;
                WrEn    <= 1'b1;
                r_state <= S_OPB;
              end
              S_OPB: begin
                Address     <= ADDR_WIDTH'(1);
                WrData      <= RX_P_DATA;
                WrEn        <= 1'b1;
                CLK_GATE_EN <= 1'b1;
                r_state     <= S_FUN;
              end
              default: begin
                ALU_FUN     <= RX_P_DATA[FUN_WIDTH-1:0];
                ALU_EN      <= 1'b1;
                CLK_GATE_EN <= 1'b1;
                r_state     <= S_ALU_WAIT;
              end
            endcase
          end else if (w_timeout) begin
            CMD_ERR     <= 1'b1;
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_rx_cmd_ctrl.sv
// tb/tb_sys_rx_cmd_ctrl.sv - scoreboard bench for sys_rx_cmd_ctrl
module tb_sys_rx_cmd_ctrl;

  localparam int TO = 1023;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VALID = 1'b0;
  logic       ALU_OUT_VALID = 1'b0;
  logic       WrEn, RdEn, ALU_EN, CLK_GATE_EN, CMD_ERR;
  logic [3:0] Address, ALU_FUN;
  logic [7:0] WrData;

  typedef struct packed {
    logic [1:0] kind;   // 1 write, 2 read, 3 error
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  total = 0;
  int  bad   = 0;
  logic [3:0] exp_addr = 4'h0;
  logic [7:0] exp_wdata = 8'h00;
  logic [3:0] exp_fun = 4'h0;

  sys_rx_cmd_ctrl #(.WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VALID(RX_D_VALID),
    .ALU_OUT_VALID(ALU_OUT_VALID), .WrEn(WrEn), .RdEn(RdEn), .Address(Address),
    .WrData(WrData), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN),
    .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  // record every strobe the DUT produces
  always @(negedge CLK) begin
    if (RST) begin
      if (WrEn)    obs_q.push_back({2'd1, Address, WrData});
      if (RdEn)    obs_q.push_back({2'd2, Address, 8'h00});
      if (CMD_ERR) obs_q.push_back({2'd3, 4'h0, 8'h00});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_P_DATA = b;
    RX_D_VALID = 1'b1;
    @(posedge CLK); #1;
    RX_D_VALID = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if ({WrEn, RdEn, Address, WrData, ALU_FUN, ALU_EN, CLK_GATE_EN, CMD_ERR} !== 23'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0",
               {WrEn, RdEn, Address, WrData, ALU_FUN, ALU_EN, CLK_GATE_EN, CMD_ERR});
    end
    RST = 1'b1;
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_write;
    ev_t e, o;
    exp_q.push_back({2'd1, 4'h5, 8'h3C});
    send(8'hAA); send(8'h05); send(8'h3C);
    exp_addr = 4'h5; exp_wdata = 8'h3C;
    repeat (2) @(posedge CLK); #1;
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL write_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.kind !== e.kind || (e.kind != 2'd3 && (o.addr !== e.addr || o.data !== e.data))) begin
        bad++; $display("FAIL write_event got=%h exp=%h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_read;
    ev_t e, o;
    exp_q.push_back({2'd2, 4'h7, 8'h00});
    send(8'hBB); send(8'h17);
    exp_addr = 4'h7;
    repeat (2) @(posedge CLK); #1;
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL read_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.kind !== e.kind || (e.kind != 2'd3 && (o.addr !== e.addr || o.data !== e.data))) begin
        bad++; $display("FAIL read_event got=%h exp=%h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_alu_ops;
    ev_t e, o;
    exp_q.push_back({2'd1, 4'h0, 8'h0A});
    exp_q.push_back({2'd1, 4'h1, 8'h03});
    send(8'hCC); send(8'h0A);
    total++;
    if (CLK_GATE_EN !== 1'b0) begin
      bad++; $display("FAIL alu_gate_early got=%b exp=0", CLK_GATE_EN);
    end
    send(8'h03);
    total++;
    if ({WrEn, CLK_GATE_EN, ALU_EN} !== 3'b110) begin
      bad++; $display("FAIL alu_gate_with_opb got=%b exp=110", {WrEn, CLK_GATE_EN, ALU_EN});
    end
    send(8'h02);
    exp_addr = 4'h1; exp_wdata = 8'h03; exp_fun = 4'h2;
    total++;
    if ({ALU_FUN, ALU_EN, CLK_GATE_EN} !== {4'h2, 2'b11}) begin
      bad++; $display("FAIL alu_start got=%h exp=%h", {ALU_FUN, ALU_EN, CLK_GATE_EN}, {4'h2, 2'b11});
    end
    repeat (4) @(posedge CLK);
    #1 ALU_OUT_VALID = 1'b1;
    total++;
    if ({ALU_EN, CLK_GATE_EN} !== 2'b11) begin
      bad++; $display("FAIL alu_hold got=%b exp=11", {ALU_EN, CLK_GATE_EN});
    end
    @(posedge CLK); #1 ALU_OUT_VALID = 1'b0;
    total++;
    if ({ALU_EN, CLK_GATE_EN} !== 2'b00) begin
      bad++; $display("FAIL alu_done got=%b exp=00", {ALU_EN, CLK_GATE_EN});
    end
    repeat (2) @(posedge CLK); #1;
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL alu_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.kind !== e.kind || (e.kind != 2'd3 && (o.addr !== e.addr || o.data !== e.data))) begin
        bad++; $display("FAIL alu_event got=%h exp=%h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_alu_noop;
    send(8'hDD);
    total++;
    if ({ALU_EN, CLK_GATE_EN} !== 2'b00) begin
      bad++; $display("FAIL noop_early got=%b exp=00", {ALU_EN, CLK_GATE_EN});
    end
    send(8'h01);
    exp_fun = 4'h1;
    total++;
    if ({ALU_FUN, ALU_EN, CLK_GATE_EN} !== {4'h1, 2'b11}) begin
      bad++; $display("FAIL noop_start got=%h exp=%h", {ALU_FUN, ALU_EN, CLK_GATE_EN}, {4'h1, 2'b11});
    end
    repeat (3) @(posedge CLK);
    #1 ALU_OUT_VALID = 1'b1;
    @(posedge CLK); #1 ALU_OUT_VALID = 1'b0;
    total++;
    if ({ALU_EN, CLK_GATE_EN} !== 2'b00) begin
      bad++; $display("FAIL noop_done got=%b exp=00", {ALU_EN, CLK_GATE_EN});
    end
    repeat (2) @(posedge CLK); #1;
    total++;
    if (obs_q.size() !== 0) begin
      bad++; $display("FAIL noop_events got=%0d exp=0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_bad_opcode;
    ev_t e, o;
    exp_q.push_back({2'd3, 4'h0, 8'h00});
    send(8'h55);
    total++;
    if ({Address, WrData, ALU_FUN, ALU_EN, CLK_GATE_EN} !== {exp_addr, exp_wdata, exp_fun, 2'b00}) begin
      bad++; $display("FAIL badop_outputs got=%h exp=%h",
                      {Address, WrData, ALU_FUN, ALU_EN, CLK_GATE_EN}, {exp_addr, exp_wdata, exp_fun, 2'b00});
    end
    repeat (2) @(posedge CLK); #1;
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL badop_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.kind !== e.kind) begin
        bad++; $display("FAIL badop_event got=%h exp=%h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_alu_drop;
    ev_t e, o;
    send(8'hDD); send(8'h03);
    exp_q.push_back({2'd3, 4'h0, 8'h00});
    send(8'h77);
    total++;
    if ({CMD_ERR, ALU_EN, CLK_GATE_EN} !== 3'b111) begin
      bad++; $display("FAIL drop_busy got=%b exp=111", {CMD_ERR, ALU_EN, CLK_GATE_EN});
    end
    exp_q.push_back({2'd3, 4'h0, 8'h00});
    @(posedge CLK); #1;
    RX_P_DATA = 8'h12; RX_D_VALID = 1'b1; ALU_OUT_VALID = 1'b1;
    @(posedge CLK); #1;
    RX_D_VALID = 1'b0; ALU_OUT_VALID = 1'b0;
    total++;
    if ({CMD_ERR, ALU_EN, CLK_GATE_EN} !== 3'b100) begin
      bad++; $display("FAIL drop_collide got=%b exp=100", {CMD_ERR, ALU_EN, CLK_GATE_EN});
    end
    repeat (2) @(posedge CLK); #1;
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL drop_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.kind !== e.kind) begin
        bad++; $display("FAIL drop_event got=%h exp=%h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout;
    ev_t e, o;
    int  waited;
    exp_q.push_back({2'd3, 4'h0, 8'h00});
    send(8'hAA); send(8'h03);
    waited = 0;
    for (int i = 1; i <= TO + 20; i++) begin
      if (waited == 0) begin
        @(posedge CLK); #1;
        if (CMD_ERR) waited = i;
      end
    end
    total++;
    if (waited < TO || waited > TO + 1) begin
      bad++; $display("FAIL timeout_latency got=%0d exp=%0d..%0d", waited, TO, TO + 1);
    end
    exp_q.push_back({2'd2, 4'h3, 8'h00});
    send(8'hBB); send(8'h03);
    repeat (2) @(posedge CLK); #1;
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL timeout_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.kind !== e.kind || (e.kind != 2'd3 && (o.addr !== e.addr || o.data !== e.data))) begin
        bad++; $display("FAIL timeout_event got=%h exp=%h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    ev_t e, o;
    logic [7:0] frames [5];
    frames = '{8'hAA, 8'h02, 8'h11, 8'hBB, 8'h04};
    exp_q.push_back({2'd1, 4'h2, 8'h11});
    exp_q.push_back({2'd2, 4'h4, 8'h00});
    @(posedge CLK); #1;
    for (int i = 0; i < 5; i++) begin
      RX_P_DATA = frames[i];
      RX_D_VALID = 1'b1;
      @(posedge CLK); #1;
    end
    RX_D_VALID = 1'b0;
    repeat (2) @(posedge CLK); #1;
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.kind !== e.kind || (e.kind != 2'd3 && (o.addr !== e.addr || o.data !== e.data))) begin
        bad++; $display("FAIL b2b_event got=%h exp=%h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid;
    ev_t e, o;
    send(8'hDD); send(8'h04);
    total++;
    if ({ALU_EN, CLK_GATE_EN} !== 2'b11) begin
      bad++; $display("FAIL rstmid_busy got=%b exp=11", {ALU_EN, CLK_GATE_EN});
    end
    #2 RST = 1'b0;
    #1;
    total++;
    if ({WrEn, RdEn, Address, WrData, ALU_FUN, ALU_EN, CLK_GATE_EN, CMD_ERR} !== 23'd0) begin
      bad++; $display("FAIL rstmid_outputs got=%h exp=0",
                      {WrEn, RdEn, Address, WrData, ALU_FUN, ALU_EN, CLK_GATE_EN, CMD_ERR});
    end
    @(posedge CLK); #1 RST = 1'b1;
    obs_q.delete();
    exp_q.push_back({2'd2, 4'h2, 8'h00});
    send(8'hBB); send(8'h02);
    repeat (2) @(posedge CLK); #1;
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL rstmid_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.kind !== e.kind || o.addr !== e.addr || o.data !== e.data) begin
        bad++; $display("FAIL rstmid_event got=%h exp=%h", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alu_ops();
    test_alu_noop();
    test_bad_opcode();
    test_alu_drop();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sys_rx_cmd_ctrl.md
# sys_rx_cmd_ctrl

Receive-side command sequencer of the system controller. It parses UART RX frames (one RX_D_VALID pulse per byte) into the four supported commands. It then drives the register file (write/read), the ALU (function, enable) and the ALU clock-gate enable. It runs in the reference clock domain next to the TX result controller, which independently watches the same RX frame stream to know which result to send.

## Interface
Parameters:
- WIDTH, 8, RX frame / register data width
- ADDR_WIDTH, 4, register file address width
- FUN_WIDTH, 4, ALU function code width
- TIMEOUT_CYCLES, 1023, max idle cycles between frames of one command (and max ALU wait) before abort

Ports:
- CLK  in  1  reference clock
- RST  in  1  reset, asynchronous, active-low
- RX_P_DATA  in  WIDTH  received frame, valid only when RX_D_VALID=1
- RX_D_VALID  in  1  single-cycle strobe per received frame
- ALU_OUT_VALID  in  1  ALU result valid strobe
- WrEn  out  1  register file write strobe, 1-cycle pulse
- RdEn  out  1  register file read strobe, 1-cycle pulse
- Address  out  ADDR_WIDTH  register file address, held between commands
- WrData  out  WIDTH  register file write data
- ALU_FUN  out  FUN_WIDTH  ALU function, held
- ALU_EN  out  1  ALU enable, level
- CLK_GATE_EN  out  1  ALU clock-gate enable, level
- CMD_ERR  out  1  1-cycle pulse on protocol error/abort

## Operation
- Opcodes: 0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN, ALU_WAIT.
- IDLE:
  - 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->OPA, 0xDD->FUN.
  - Any other byte: CMD_ERR pulse, remain IDLE.
- WR_ADDR: frame -> Address=RX_P_DATA[ADDR_WIDTH-1:0] (upper bits ignored); ->WR_DATA.
- WR_DATA: frame -> WrData=frame, WrEn pulse; ->IDLE.
- RD_ADDR: frame -> Address=frame[ADDR_WIDTH-1:0], RdEn pulse; ->IDLE.
- OPA: frame -> Address=0x0, WrData=frame, WrEn pulse; ->OPB.
- OPB: frame -> Address=0x1, WrData=frame, WrEn pulse, CLK_GATE_EN=1; ->FUN.
- FUN: frame -> ALU_FUN=frame[FUN_WIDTH-1:0], ALU_EN=1, CLK_GATE_EN=1; ->ALU_WAIT.
- ALU_WAIT:
  - On ALU_OUT_VALID: ALU_EN=0, CLK_GATE_EN=0; ->IDLE.
  - RX_D_VALID here (frame not consumed): frame dropped, CMD_ERR pulse, stay.
  - ALU_OUT_VALID and RX_D_VALID in the same cycle: completion wins, frame dropped, CMD_ERR pulse.
- Timeout counter:
  - Clears on every accepted frame and on entry to any state.
  - Counts every cycle outside IDLE.
  - On reaching TIMEOUT_CYCLES: CMD_ERR pulse, ALU_EN=0, CLK_GATE_EN=0, ->IDLE. No WrEn/RdEn issued.
- ALU_OUT_VALID outside ALU_WAIT is ignored.
- Counter width: ceil(log2(TIMEOUT_CYCLES+1)). It saturates and never wraps.

## Timing
- All outputs registered.
- Reset values: WrEn=0, RdEn=0, Address=0, WrData=0, ALU_FUN=0, ALU_EN=0, CLK_GATE_EN=0, CMD_ERR=0, state IDLE, counter 0.
- Latency:
  - WrEn/RdEn/CMD_ERR assert in the cycle after the triggering RX_D_VALID edge.
  - Address/WrData are valid in that same cycle.
- OPB: CLK_GATE_EN rises in the same cycle as the operand-B WrEn, at least one full frame time before ALU_EN.
- 0xDD path: CLK_GATE_EN and ALU_EN rise together in the cycle after the function frame.
- ALU_EN and CLK_GATE_EN fall in the cycle after ALU_OUT_VALID.
- Back-to-back commands: the opcode frame may arrive in the cycle immediately after returning to IDLE.
- Reset mid-command (any state): all outputs return to reset values immediately (asynchronous); the partial command is discarded.

## Test plan
- Write: frames 0xAA,0x05,0x3C -> one WrEn pulse with Address=0x5, WrData=0x3C; state IDLE.
- Read: frames 0xBB,0x17 -> one RdEn pulse with Address=0x7; no WrEn.
- ALU with operands: frames 0xCC,0x0A,0x03,0x02, then ALU_OUT_VALID 5 cycles later.
  - WrEn to address 0x0 with data 0x0A, then to 0x1 with 0x03.
  - CLK_GATE_EN high from the second WrEn.
  - ALU_FUN=0x2 and ALU_EN high after frame 4.
  - Both enables low the cycle after ALU_OUT_VALID.
- ALU without operands: frames 0xDD,0x01 -> no WrEn; ALU_FUN=0x1, ALU_EN=CLK_GATE_EN=1 until ALU_OUT_VALID.
- Errors:
  - 0x55 in IDLE -> CMD_ERR pulse, no other outputs change.
  - 0xAA,0x03 then silence for TIMEOUT_CYCLES -> CMD_ERR pulse, no WrEn; a following 0xBB,0x03 completes normally.
- Reset: RST low during ALU_WAIT -> ALU_EN, CLK_GATE_EN and all outputs 0 immediately; after release, 0xBB,0x02 -> RdEn with Address=0x2.
